// File: rtl/cam_capture_ctrl.sv
// OV7670 byte-stream capture: pairs bytes into RGB565 pixels, decimates, optionally
// converts to grayscale and queues pixel/address pairs for the SDRAM write port.
module cam_capture_ctrl #(
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_ce,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              enable,
  input  logic              gray_mode,
  input  logic [1:0]        decim,
  output logic [15:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_start,
  output logic              frame_done,
  output logic              overflow,
  output logic [7:0]        frame_cnt
);

  localparam int XW = $clog2(H_ACT + 1);
  localparam int YW = $clog2(V_ACT + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 16 + ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic              vsync_prev_reg, href_prev_reg;
  logic              gray_reg;
  logic [1:0]        decim_reg;
  logic              phase_reg;
  logic [7:0]        hi_reg;
  logic [XW-1:0]     x_in_reg;
  logic [YW-1:0]     y_in_reg;
  logic [ADDR_W-1:0] x_out_reg, line_base_reg;
  logic              st_valid_reg;
  logic [15:0]       st_data_reg;
  logic [ADDR_W-1:0] st_addr_reg;
  logic              frame_start_reg, frame_done_reg, overflow_reg;
  logic [7:0]        frame_cnt_reg;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg;

  logic vs_fall, vs_rise, start_frame, end_frame;
  logic capture, pix_done, pix_keep, line_end, x_ok, y_ok;
  logic [1:0] decim_eff, dmask, x_lo, y_lo;
  logic [ADDR_W-1:0] width_out;
  logic [4:0]  r5, b5, y5;
  logic [5:0]  g6, y6;
  logic [10:0] luma_sum;
  logic [15:0] pix_word;
  logic push, pop, full, wr_en, drop;
  logic [EW-1:0] head;

  // Camera edges only exist on strobed samples.
  assign vs_fall = cam_ce &  vsync_prev_reg & ~cam_vsync;
  assign vs_rise = cam_ce & ~vsync_prev_reg &  cam_vsync;

  always_comb begin
    state_next  = state_reg;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) state_next = WAIT_VS;
      end
      WAIT_VS: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (vs_fall) begin
          state_next  = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          state_next = DONE;
          end_frame  = 1'b1;
        end
      end
      DONE: begin
        state_next = enable ? WAIT_VS : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  assign decim_eff = (decim_reg == 2'd3) ? 2'd0 : decim_reg;
  assign dmask     = (decim_eff == 2'd2) ? 2'b11 : ((decim_eff == 2'd1) ? 2'b01 : 2'b00);
  assign x_lo      = 2'(x_in_reg);
  assign y_lo      = 2'(y_in_reg);
  assign x_ok      = (x_in_reg < XW'(H_ACT)) && ((x_lo & dmask) == 2'b00);
  assign y_ok      = (y_in_reg < YW'(V_ACT)) && ((y_lo & dmask) == 2'b00);
  assign width_out = ADDR_W'(H_ACT >> decim_eff);

  assign capture  = (state_reg == ACTIVE) && cam_ce;
  assign pix_done = capture && cam_href && phase_reg;
  assign pix_keep = pix_done && x_ok && y_ok;
  assign line_end = capture && href_prev_reg && !cam_href;

  // Luma from the full 11-bit weighted sum, then replicated back into RGB565 lanes.
  assign r5       = hi_reg[7:3];
  assign g6       = {hi_reg[2:0], cam_data[7:5]};
  assign b5       = cam_data[4:0];
  assign luma_sum = {2'b00, r5, 4'b0000} + (11'(g6) * 11'd20) + {3'b000, b5, 3'b000};
  assign y5       = 5'(luma_sum >> 6);
  assign y6       = 6'(luma_sum >> 5);
  assign pix_word = gray_reg ? {y5, y6, y5} : {hi_reg, cam_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev_reg  <= 1'b0;
      href_prev_reg   <= 1'b0;
      gray_reg        <= 1'b0;
      decim_reg       <= 2'd0;
      phase_reg       <= 1'b0;
      hi_reg          <= 8'd0;
      x_in_reg        <= '0;
      y_in_reg        <= '0;
      x_out_reg       <= '0;
      line_base_reg   <= '0;
      st_valid_reg    <= 1'b0;
      st_data_reg     <= 16'd0;
      st_addr_reg     <= '0;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_cnt_reg   <= 8'd0;
    end else begin
      if (cam_ce) begin
        vsync_prev_reg <= cam_vsync;
        href_prev_reg  <= cam_href;
      end
      frame_start_reg <= start_frame;
      frame_done_reg  <= end_frame;
      if (end_frame) frame_cnt_reg <= frame_cnt_reg + 8'd1;

      if (start_frame) begin
        gray_reg      <= gray_mode;
        decim_reg     <= decim;
        phase_reg     <= 1'b0;
        x_in_reg      <= '0;
        y_in_reg      <= '0;
        x_out_reg     <= '0;
        line_base_reg <= '0;
      end else if (line_end) begin
        phase_reg <= 1'b0;
        x_in_reg  <= '0;
        x_out_reg <= '0;
        if (y_in_reg < YW'(V_ACT)) y_in_reg <= y_in_reg + YW'(1);
        // A kept line advances the output row even if it was short.
        if (y_ok) line_base_reg <= line_base_reg + width_out;
      end else if (capture && cam_href) begin
        phase_reg <= ~phase_reg;
        if (!phase_reg) hi_reg <= cam_data;
        if (phase_reg && (x_in_reg < XW'(H_ACT))) x_in_reg <= x_in_reg + XW'(1);
        if (pix_keep) x_out_reg <= x_out_reg + ADDR_W'(1);
      end

      st_valid_reg <= pix_keep;
      if (pix_keep) begin
        st_data_reg <= pix_word;
        st_addr_reg <= line_base_reg + x_out_reg;
      end
    end
  end

  assign full  = (count_reg == CW'(FIFO_DEPTH));
  assign pop   = (count_reg != '0) && out_ready;
  assign push  = st_valid_reg;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr_reg == PW'(gi))) mem[gi] <= {st_data_reg, st_addr_reg};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (wr_en && !pop)      count_reg <= count_reg + CW'(1);
      else if (!wr_en && pop) count_reg <= count_reg - CW'(1);
      if (drop) overflow_reg <= 1'b1;
    end
  end

  assign head        = mem[rd_ptr_reg];
  assign out_valid   = (count_reg != '0);
  assign out_data    = out_valid ? head[EW-1:ADDR_W] : 16'd0;
  assign out_addr    = out_valid ? head[ADDR_W-1:0] : '0;
  assign frame_start = frame_start_reg;
  assign frame_done  = frame_done_reg;
  assign overflow    = overflow_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl: drives camera frames, predicts each kept
// pixel/address, and checks them as the output FIFO is drained.
module tb_cam_capture_ctrl;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 16;
  localparam int FD = 4;

  logic          clk, rst, cam_ce, cam_vsync, cam_href, enable, gray_mode, out_ready;
  logic [7:0]    cam_data;
  logic [1:0]    decim;
  logic [15:0]   out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid, frame_start, frame_done, overflow;
  logic [7:0]    frame_cnt;

  cam_capture_ctrl #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .cam_ce(cam_ce), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .enable(enable), .gray_mode(gray_mode), .decim(decim),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .frame_start(frame_start), .frame_done(frame_done), .overflow(overflow),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]   data;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          fs_seen = 0;
  int          fd_seen = 0;
  int          m_gray = 0;
  int          m_decim = 0;
  logic [15:0] line_pix [16];
  logic [15:0] tab [8] = '{16'hF800, 16'hFFFF, 16'h07E0, 16'h001F,
                           16'h1234, 16'h8421, 16'h0000, 16'hABCD};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] gray_fn(input logic [15:0] p);
    int r, g, b, y;
    logic [7:0] y8;
    r  = int'(p[15:11]);
    g  = int'(p[10:5]);
    b  = int'(p[4:0]);
    y  = (r * 2 * 8 + g * 5 * 4 + b * 8) >> 3;
    y8 = 8'(y);
    return {y8[7:3], y8[7:2], y8[7:3]};
  endfunction

  function automatic bit keep(input int x, input int y);
    int s;
    s = 1 << m_decim;
    return (x < H) && (y < V) && (x % s == 0) && (y % s == 0);
  endfunction

  // One line per consumed transaction, checked against the scoreboard head.
  always @(negedge clk) begin
    if (frame_start) fs_seen++;
    if (frame_done)  fd_seen++;
    if (!rst && out_valid && out_ready) begin
      $display("pop  addr=%0d data=0x%04h", out_addr, out_data);
      if (exp_q.size() == 0) begin
        chk("extra_pixel", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pix_data", 32'(out_data), 32'(e.data));
        chk("pix_addr", 32'(out_addr), 32'(e.addr));
      end
    end
  end

  task automatic cam_byte(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge clk); #1;
    cam_ce = 1'b1; cam_vsync = vs; cam_href = hr; cam_data = d;
    @(posedge clk); #1;
    cam_ce = 1'b0; cam_vsync = 1'($urandom); cam_href = 1'($urandom); cam_data = 8'($urandom);
  endtask

  task automatic frame_begin();
    m_gray  = int'(gray_mode);
    m_decim = (decim == 2'd3) ? 0 : int'(decim);
    cam_byte(1'b1, 1'b0, 8'h00);
    cam_byte(1'b1, 1'b0, 8'h00);
    cam_byte(1'b0, 1'b0, 8'h00);
    cam_byte(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int y, input int ppl, input bit exp_en, input bit use_tab,
                           input bit tail);
    for (int x = 0; x < ppl; x++) begin
      logic [15:0] pv;
      exp_t e;
      pv = use_tab ? tab[x % 8] : 16'($urandom);
      line_pix[x % 16] = pv;
      cam_byte(1'b0, 1'b1, pv[15:8]);
      if (exp_en && keep(x, y)) begin
        e.data = (m_gray != 0) ? gray_fn(pv) : pv;
        e.addr = AW'((y >> m_decim) * (H >> m_decim) + (x >> m_decim));
        exp_q.push_back(e);
      end
      cam_byte(1'b0, 1'b1, pv[7:0]);
    end
    if (tail) cam_byte(1'b0, 1'b1, 8'h5A);
    cam_byte(1'b0, 1'b0, 8'h00);
    cam_byte(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_end();
    cam_byte(1'b1, 1'b0, 8'h00);
    cam_byte(1'b1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int lines, input int ppl, input bit exp_en, input bit use_tab);
    frame_begin();
    for (int y = 0; y < lines; y++) send_line(y, ppl, exp_en, use_tab, y == 1);
    frame_end();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fs0, fd0;
    exp_t e;
    rst = 1'b1; cam_ce = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    enable = 1'b0; gray_mode = 1'b0; decim = 2'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_fstart", 32'(frame_start), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;

    // 1:1 RGB, full 8x4 frame with a lone trailing byte on line 1
    enable = 1'b1;
    send_frame(4, 8, 1'b1, 1'b0);
    drain();
    chk("f1_starts", 32'(fs_seen), 32'd1);
    chk("f1_dones", 32'(fd_seen), 32'd1);
    chk("f1_fcnt", 32'(frame_cnt), 32'd1);
    chk("f1_ovf", 32'(overflow), 32'd0);

    // 1:2 decimation
    decim = 2'd1;
    send_frame(4, 8, 1'b1, 1'b0);
    drain();
    chk("f2_fcnt", 32'(frame_cnt), 32'd2);

    // reserved decim with oversized lines and an extra line beyond V_ACT
    decim = 2'd3;
    send_frame(5, 10, 1'b1, 1'b0);
    drain();
    chk("f3_fcnt", 32'(frame_cnt), 32'd3);

    // 1:4 decimation
    decim = 2'd2;
    send_frame(4, 8, 1'b1, 1'b0);
    drain();

    // grayscale over a fixed colour table (pure red lands on 0x39E7)
    decim = 2'd0; gray_mode = 1'b1;
    send_frame(1, 8, 1'b1, 1'b1);
    drain();
    chk("f5_fcnt", 32'(frame_cnt), 32'd5);

    // consumer stalled for a whole line: FIFO fills, the rest is dropped
    gray_mode = 1'b0; out_ready = 1'b0;
    frame_begin();
    send_line(0, 8, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("ovf_valid", 32'(out_valid), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head_addr", 32'(out_addr), 32'd0);
    chk("ovf_head_data", 32'(out_data), 32'(line_pix[0]));
    repeat (5) @(posedge clk);
    #1;
    chk("ovf_hold_addr", 32'(out_addr), 32'd0);
    chk("ovf_hold_data", 32'(out_data), 32'(line_pix[0]));
    for (int i = 0; i < FD; i++) begin
      e.data = line_pix[i];
      e.addr = AW'(i);
      exp_q.push_back(e);
    end
    out_ready = 1'b1;
    drain();
    send_line(1, 8, 1'b1, 1'b0, 1'b0);
    frame_end();
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("f6_fcnt", 32'(frame_cnt), 32'd6);

    // enable dropped mid-frame: frame still completes, then no further capture
    fs0 = fs_seen; fd0 = fd_seen;
    frame_begin();
    send_line(0, 8, 1'b1, 1'b0, 1'b0);
    enable = 1'b0;
    for (int y = 1; y < V; y++) send_line(y, 8, 1'b1, 1'b0, 1'b0);
    frame_end();
    drain();
    chk("endrop_done", 32'(fd_seen - fd0), 32'd1);
    chk("endrop_fcnt", 32'(frame_cnt), 32'd7);
    fs0 = fs_seen;
    send_frame(2, 8, 1'b0, 1'b0);
    chk("idle_no_start", 32'(fs_seen - fs0), 32'd0);
    chk("idle_fcnt", 32'(frame_cnt), 32'd7);
    chk("idle_valid", 32'(out_valid), 32'd0);

    // reset while ACTIVE with three entries queued
    enable = 1'b1; out_ready = 1'b0;
    frame_begin();
    send_line(0, 3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; enable = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_fcnt", 32'(frame_cnt), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    fs0 = fs_seen;
    send_frame(1, 8, 1'b0, 1'b0);
    chk("arst_idle", 32'(fs_seen - fs0), 32'd0);

    // capture resumes cleanly from IDLE
    enable = 1'b1; decim = 2'd0;
    send_frame(2, 8, 1'b1, 1'b0);
    drain();
    chk("resume_fcnt", 32'(frame_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
